blood_anim_sprite: RTL and testbench

//  Upstream driver for the blood-splatter frame ROMs (64x64, 12-bit RGB, address registered in ROM).

---
 rtl/blood_pkg.sv | 18 +
 rtl/blood_anim_ctrl.sv | 88 ++++++++
 rtl/blood_anim_sprite.sv | 73 +++++++
 tb/tb_blood_anim_sprite.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/blood_pkg.sv
// Shared constants and types for the blood-splatter sprite path.
package blood_pkg;

  localparam int SPRITE_DIM = 64;
  localparam int ADDR_W     = 6;
  localparam int COLOR_W    = 12;
  localparam int FRAME_W    = 5;
  localparam int COORD_W    = 10;

  // Black pixels in the frame ROMs are see-through.
  localparam logic [COLOR_W-1:0] TRANSPARENT = 12'h000;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/blood_anim_ctrl.sv
// One-shot animation sequencer: a trigger starts playback at frame 0, each
// frame is held for TICKS_PER_FRAME frame_tick pulses, and after the last
// frame the sequencer drops back to IDLE.
// Optional feature: define BLOOD_RETRIGGER_EN to let a trigger during
// playback restart the animation from frame 0.
module blood_anim_ctrl
  import blood_pkg::*;
#(
  parameter int NUM_FRAMES      = 20,
  parameter int TICKS_PER_FRAME = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trigger,
  input  logic               frame_tick,
  output logic               busy,
  output logic [FRAME_W-1:0] rom_frame
);

  localparam int TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_FRAME - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

  state_t             state_reg, state_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic [TICK_W-1:0]  tick_reg, tick_next;

  // State and counter registers; reset parks the sequencer in IDLE at frame 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      frame_reg <= '0;
      tick_reg  <= '0;
    end else begin
      state_reg <= state_next;
      frame_reg <= frame_next;
      tick_reg  <= tick_next;
    end
  end

  // Next-state logic; frames only advance on frame_tick so a displayed
  // frame never changes mid-scan.
  always_comb begin
    state_next = state_reg;
    frame_next = frame_reg;
    tick_next  = tick_reg;
    case (state_reg)
      IDLE: begin
        // A coincident frame_tick is ignored so frame 0 gets its full time.
        if (trigger) begin
          state_next = PLAY;
          frame_next = '0;
          tick_next  = '0;
        end
      end
      PLAY: begin
`ifdef BLOOD_RETRIGGER_EN
        if (trigger) begin
          frame_next = '0;
          tick_next  = '0;
        end else
`endif
        if (frame_tick) begin
          if (tick_reg == TICK_LAST) begin
            tick_next = '0;
            if (frame_reg == FRAME_LAST) begin
              state_next = IDLE;
              frame_next = '0;
            end else begin
              frame_next = frame_reg + 1'b1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        frame_next = '0;
        tick_next  = '0;
      end
    endcase
  end

  assign busy      = (state_reg == PLAY);
  assign rom_frame = frame_reg;

endmodule

// File: rtl/blood_anim_sprite.sv
// Blood-splatter sprite driver: sequences the animation frames, turns the
// VGA pixel position into ROM row/col addresses and masks the ROM colour
// with a window flag delayed to match the ROM's registered read.
// Optional feature: BLOOD_RETRIGGER_EN (see blood_anim_ctrl).
module blood_anim_sprite
  import blood_pkg::*;
#(
  parameter int NUM_FRAMES      = 20,
  parameter int TICKS_PER_FRAME = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trigger,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               video_on,
  output logic [ADDR_W-1:0]  rom_row,
  output logic [ADDR_W-1:0]  rom_col,
  output logic [FRAME_W-1:0] rom_frame,
  input  logic [COLOR_W-1:0] rom_color,
  output logic               busy,
  output logic               blood_on,
  output logic [COLOR_W-1:0] rgb
);

  logic               in_box;
  logic               in_box_d;
  logic [COORD_W:0]   x_w, y_w, left_w, right_w, top_w, bottom_w;

  blood_anim_ctrl #(
    .NUM_FRAMES      (NUM_FRAMES),
    .TICKS_PER_FRAME (TICKS_PER_FRAME)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .frame_tick (frame_tick),
    .busy       (busy),
    .rom_frame  (rom_frame)
  );

  // Low 6 bits of the difference only depend on the low 6 bits of each term.
  assign rom_col = x[ADDR_W-1:0] - pos_x[ADDR_W-1:0];
  assign rom_row = y[ADDR_W-1:0] - pos_y[ADDR_W-1:0];

  // Window compare is one bit wider so pos+64 cannot wrap at the screen edge.
  assign x_w      = {1'b0, x};
  assign y_w      = {1'b0, y};
  assign left_w   = {1'b0, pos_x};
  assign top_w    = {1'b0, pos_y};
  assign right_w  = left_w + (COORD_W+1)'(SPRITE_DIM);
  assign bottom_w = top_w + (COORD_W+1)'(SPRITE_DIM);

  assign in_box = busy & video_on
                & (x_w >= left_w) & (x_w < right_w)
                & (y_w >= top_w)  & (y_w < bottom_w);

  // Delay the window flag one clock so it lines up with the ROM data.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_box_d <= 1'b0;
    end else begin
      in_box_d <= in_box;
    end
  end

  assign blood_on = in_box_d & (rom_color != TRANSPARENT);
  assign rgb      = blood_on ? rom_color : TRANSPARENT;

endmodule

// File: tb/tb_blood_anim_sprite.sv
// Scoreboard bench for blood_anim_sprite: stimulus pushes expectations
// tagged with the cycle they apply to, a negedge monitor pops and compares.
module tb_blood_anim_sprite;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic        frame_tick;
  logic [9:0]  pos_x, pos_y, x, y;
  logic        video_on;
  logic [5:0]  rom_row, rom_col;
  logic [4:0]  rom_frame;
  logic [11:0] rom_color;
  logic        busy, blood_on;
  logic [11:0] rgb;

  blood_anim_sprite #(.NUM_FRAMES(20), .TICKS_PER_FRAME(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .frame_tick (frame_tick),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_frame  (rom_frame),
    .rom_color  (rom_color),
    .busy       (busy),
    .blood_on   (blood_on),
    .rgb        (rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       name;
    bit          chk_ctrl;
    bit          chk_addr;
    bit          chk_pix;
    logic        busy;
    logic [4:0]  frame;
    logic [5:0]  row;
    logic [5:0]  col;
    logic        on;
    logic [11:0] rgb;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that has come due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.due < cyc) begin
        checks++; errors++;
        $display("FAIL %s: stale entry due %0d seen at cyc %0d", mon_e.name, mon_e.due, cyc);
      end else begin
        if (mon_e.chk_ctrl) begin
          checks++;
          if (busy !== mon_e.busy) begin
            errors++;
            $display("FAIL %s: busy got %0b want %0b", mon_e.name, busy, mon_e.busy);
          end
          checks++;
          if (rom_frame !== mon_e.frame) begin
            errors++;
            $display("FAIL %s: rom_frame got %0d want %0d", mon_e.name, rom_frame, mon_e.frame);
          end
        end
        if (mon_e.chk_addr) begin
          checks++;
          if (rom_row !== mon_e.row || rom_col !== mon_e.col) begin
            errors++;
            $display("FAIL %s: row/col got %0d/%0d want %0d/%0d", mon_e.name, rom_row, rom_col, mon_e.row, mon_e.col);
          end
        end
        if (mon_e.chk_pix) begin
          checks++;
          if (blood_on !== mon_e.on || rgb !== mon_e.rgb) begin
            errors++;
            $display("FAIL %s: blood_on/rgb got %0b/%h want %0b/%h", mon_e.name, blood_on, rgb, mon_e.on, mon_e.rgb);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t blank(input string name);
    exp_t e;
    e.due = cyc; e.name = name;
    e.chk_ctrl = 0; e.chk_addr = 0; e.chk_pix = 0;
    e.busy = 0; e.frame = 0; e.row = 0; e.col = 0; e.on = 0; e.rgb = 0;
    return e;
  endfunction

  task automatic exp_ctrl(input string name, input logic b, input logic [4:0] f);
    exp_t e = blank(name);
    e.chk_ctrl = 1; e.busy = b; e.frame = f;
    sb.push_back(e);
  endtask

  task automatic exp_addr(input string name, input logic [5:0] r, input logic [5:0] c);
    exp_t e = blank(name);
    e.chk_addr = 1; e.row = r; e.col = c;
    sb.push_back(e);
  endtask

  task automatic exp_pix(input string name, input logic on, input logic [11:0] v);
    exp_t e = blank(name);
    e.chk_pix = 1; e.on = on; e.rgb = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Present a pixel, check its address now and its masked colour one clock later.
  task automatic pix(input string name, input logic [9:0] px, input logic [9:0] py,
                     input logic vo, input logic [11:0] col_next,
                     input logic [5:0] er, input logic [5:0] ec,
                     input logic eon, input logic [11:0] ergb);
    x = px; y = py; video_on = vo;
    exp_addr({name, "_addr"}, er, ec);
    step();
    rom_color = col_next;
    exp_pix({name, "_pix"}, eon, ergb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1; trigger = 0; frame_tick = 0;
    pos_x = 10'd100; pos_y = 10'd50; x = 0; y = 0; video_on = 0; rom_color = 0;
    repeat (3) step();
    reset = 0;
    exp_ctrl("reset_ctrl", 0, 0);
    exp_pix("reset_pix", 0, 12'h000);
    step();

    // Full animation: 20 frames x 3 ticks.
    trigger = 1; step(); trigger = 0;
    exp_ctrl("start", 1, 0);
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k < 60) exp_ctrl($sformatf("play_t%0d", k), 1, 5'(k / 3));
      else        exp_ctrl("play_done", 0, 0);
      step();
    end

    // Pixel path while busy.
    trigger = 1; step(); trigger = 0;
    exp_ctrl("pix_start", 1, 0);
    pix("origin",     10'd100, 10'd50,  1, 12'hE00, 6'd0,  6'd0,  1, 12'hE00);
    pix("corner",     10'd163, 10'd113, 1, 12'h0F0, 6'd63, 6'd63, 1, 12'h0F0);
    pix("x_past",     10'd164, 10'd60,  1, 12'hABC, 6'd10, 6'd0,  0, 12'h000);
    pix("y_past",     10'd110, 10'd114, 1, 12'hABC, 6'd0,  6'd10, 0, 12'h000);
    pix("x_before",   10'd99,  10'd50,  1, 12'hABC, 6'd0,  6'd63, 0, 12'h000);
    pix("y_before",   10'd120, 10'd49,  1, 12'hABC, 6'd63, 6'd20, 0, 12'h000);
    pix("video_off",  10'd120, 10'd60,  0, 12'hABC, 6'd10, 6'd20, 0, 12'h000);
    pix("transp",     10'd120, 10'd60,  1, 12'h000, 6'd10, 6'd20, 0, 12'h000);
    pix("inner",      10'd120, 10'd60,  1, 12'h123, 6'd10, 6'd20, 1, 12'h123);
    pos_x = 10'd1000; pos_y = 10'd460;
    pix("edge_in",    10'd1023, 10'd470, 1, 12'hFFF, 6'd10, 6'd23, 1, 12'hFFF);
    pix("edge_out",   10'd5,    10'd470, 1, 12'hFFF, 6'd10, 6'd29, 0, 12'h000);
    pos_x = 10'd100; pos_y = 10'd50;

    // Reset held mid-animation with an opaque pixel in flight.
    for (int k = 1; k <= 4; k++) begin tick(); step(); end
    exp_ctrl("pre_reset", 1, 1);
    x = 10'd100; y = 10'd50; video_on = 1; rom_color = 12'hE00;
    step();
    exp_pix("pre_reset_pix", 1, 12'hE00);
    reset = 1; step();
    exp_ctrl("mid_reset_ctrl", 0, 0);
    exp_pix("mid_reset_pix", 0, 12'h000);
    step(); step();
    reset = 0; step();

    // Idle: in-box opaque pixel stays hidden.
    step();
    exp_pix("idle_hidden", 0, 12'h000);

    // Trigger with coincident tick, then retrigger at frame 7.
    trigger = 1; frame_tick = 1; step(); trigger = 0; frame_tick = 0;
    exp_ctrl("start_tick", 1, 0);
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 2 || k == 3 || k == 21) exp_ctrl($sformatf("rt_t%0d", k), 1, 5'(k / 3));
      step();
    end
    trigger = 1; step(); trigger = 0;
`ifdef BLOOD_RETRIGGER_EN
    exp_ctrl("retrig", 1, 0);
`else
    exp_ctrl("retrig", 1, 7);
`endif
    for (int k = 1; k <= 3; k++) begin tick(); step(); end
`ifdef BLOOD_RETRIGGER_EN
    exp_ctrl("retrig_next", 1, 1);
`else
    exp_ctrl("retrig_next", 1, 8);
`endif

    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
